// File: rtl/ex_wb_stage.sv
// Execute stage plus EX/WB pipeline register.
// Single-cycle ALU ops complete on the next edge. MUL runs an iterative
// shift-add multiply, one multiplier bit per edge. It stalls upstream through
// Busy for DATA_W cycles. The registered EX/WB outputs also feed the
// forwarding unit's compare.
module ex_wb_stage #(
  parameter int DATA_W  = 8,
  parameter int SHAMT_W = 3
) (
  input  logic              Clk,
  input  logic              Reset_n,
  input  logic              In_Valid,
  input  logic              Flush,
  input  logic [2:0]        ID_EX_Alu_Op,
  input  logic [DATA_W-1:0] ID_EX_Read_Data1,
  input  logic [DATA_W-1:0] ID_EX_Read_Data2,
  input  logic [2:0]        ID_EX_Write_Reg_Num,
  input  logic              ID_EX_RegWrite,
  input  logic              Fwd_signal,
  output logic              Busy,
  output logic              EX_WB_Valid,
  output logic              EX_WB_RegWrite,
  output logic [2:0]        EX_WB_Write_Reg_Num,
  output logic [DATA_W-1:0] EX_WB_Write_Data
);

  localparam logic [2:0] OP_ADD = 3'b000;
  localparam logic [2:0] OP_SUB = 3'b001;
  localparam logic [2:0] OP_AND = 3'b010;
  localparam logic [2:0] OP_OR  = 3'b011;
  localparam logic [2:0] OP_XOR = 3'b100;
  localparam logic [2:0] OP_SHL = 3'b101;
  localparam logic [2:0] OP_SHR = 3'b110;
  localparam logic [2:0] OP_MUL = 3'b111;

  typedef enum logic {
    IDLE = 1'b0,
    MUL  = 1'b1
  } state_t;

  state_t              state_reg, state_next;
  logic [SHAMT_W-1:0]  count_reg, count_next;
  logic [DATA_W-1:0]   mcand_reg, mcand_next;
  logic [DATA_W-1:0]   mplier_reg, mplier_next;
  logic [DATA_W-1:0]   acc_reg, acc_next;
  logic [2:0]          dest_reg, dest_next;
  logic                rw_reg, rw_next;

  logic                valid_reg, valid_next;
  logic                regwrite_reg, regwrite_next;
  logic [2:0]          wnum_reg, wnum_next;
  logic [DATA_W-1:0]   wdata_reg, wdata_next;

  logic [DATA_W-1:0]   op_a;
  logic [DATA_W-1:0]   op_b;
  logic [SHAMT_W-1:0]  shamt;
  logic [DATA_W-1:0]   alu_result;
  logic [DATA_W-1:0]   acc_step;
  logic                last_step;

  // Operand A is forwarded from the registered EX/WB result when requested.
  always_comb begin
    op_a  = Fwd_signal ? wdata_reg : ID_EX_Read_Data1;
    op_b  = ID_EX_Read_Data2;
    shamt = op_b[SHAMT_W-1:0];
  end

  // Single-cycle ALU; MUL is handled by the iterative datapath instead.
  always_comb begin
    alu_result = '0;
    case (ID_EX_Alu_Op)
      OP_ADD:  alu_result = op_a + op_b;
      OP_SUB:  alu_result = op_a - op_b;
      OP_AND:  alu_result = op_a & op_b;
      OP_OR:   alu_result = op_a | op_b;
      OP_XOR:  alu_result = op_a ^ op_b;
      OP_SHL:  alu_result = op_a << shamt;
      OP_SHR:  alu_result = op_a >> shamt;
      default: alu_result = '0;
    endcase
  end

  // One shift-add step; the final step's sum is the product written back.
  always_comb begin
    acc_step  = acc_reg + (mplier_reg[0] ? mcand_reg : '0);
    last_step = (count_reg == SHAMT_W'(DATA_W - 1));
  end

  // Next-state and EX/WB load logic; Flush overrides everything else.
  always_comb begin
    state_next    = state_reg;
    count_next    = count_reg;
    mcand_next    = mcand_reg;
    mplier_next   = mplier_reg;
    acc_next      = acc_reg;
    dest_next     = dest_reg;
    rw_next       = rw_reg;
    valid_next    = 1'b0;
    regwrite_next = 1'b0;
    wnum_next     = wnum_reg;
    wdata_next    = wdata_reg;

    case (state_reg)
      IDLE: begin
        if (!Flush && In_Valid) begin
          if (ID_EX_Alu_Op == OP_MUL) begin
            state_next  = MUL;
            count_next  = '0;
            mcand_next  = op_a;
            mplier_next = op_b;
            acc_next    = '0;
            dest_next   = ID_EX_Write_Reg_Num;
            rw_next     = ID_EX_RegWrite;
          end else begin
            valid_next    = 1'b1;
            regwrite_next = ID_EX_RegWrite;
            wnum_next     = ID_EX_Write_Reg_Num;
            wdata_next    = alu_result;
          end
        end
      end
      MUL: begin
        if (Flush) begin
          state_next = IDLE;
        end else begin
          acc_next    = acc_step;
          mcand_next  = mcand_reg << 1;
          mplier_next = mplier_reg >> 1;
          count_next  = count_reg + SHAMT_W'(1);
          if (last_step) begin
            state_next    = IDLE;
            valid_next    = 1'b1;
            regwrite_next = rw_reg;
            wnum_next     = dest_reg;
            wdata_next    = acc_step;
          end
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // State, multiplier and EX/WB registers with asynchronous clear.
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      state_reg    <= IDLE;
      count_reg    <= '0;
      mcand_reg    <= '0;
      mplier_reg   <= '0;
      acc_reg      <= '0;
      dest_reg     <= '0;
      rw_reg       <= 1'b0;
      valid_reg    <= 1'b0;
      regwrite_reg <= 1'b0;
      wnum_reg     <= '0;
      wdata_reg    <= '0;
    end else begin
      state_reg    <= state_next;
      count_reg    <= count_next;
      mcand_reg    <= mcand_next;
      mplier_reg   <= mplier_next;
      acc_reg      <= acc_next;
      dest_reg     <= dest_next;
      rw_reg       <= rw_next;
      valid_reg    <= valid_next;
      regwrite_reg <= regwrite_next;
      wnum_reg     <= wnum_next;
      wdata_reg    <= wdata_next;
    end
  end

  // Outputs come straight from registers.
  always_comb begin
    Busy                = (state_reg == MUL);
    EX_WB_Valid         = valid_reg;
    EX_WB_RegWrite      = regwrite_reg;
    EX_WB_Write_Reg_Num = wnum_reg;
    EX_WB_Write_Data    = wdata_reg;
  end

endmodule

// File: tb/tb_ex_wb_stage.sv
// Self-checking bench for ex_wb_stage: table of single-cycle ops plus
// hand-written multiply, flush, bubble and asynchronous reset sequences.
module tb_ex_wb_stage;
  localparam int DATA_W  = 8;
  localparam int SHAMT_W = 3;

  localparam logic [2:0] ADD = 3'b000, SUB = 3'b001, AND_ = 3'b010, OR_ = 3'b011;
  localparam logic [2:0] XOR_ = 3'b100, SHL = 3'b101, SHR = 3'b110, MUL = 3'b111;

  logic              Clk;
  logic              Reset_n;
  logic              In_Valid;
  logic              Flush;
  logic [2:0]        ID_EX_Alu_Op;
  logic [DATA_W-1:0] ID_EX_Read_Data1;
  logic [DATA_W-1:0] ID_EX_Read_Data2;
  logic [2:0]        ID_EX_Write_Reg_Num;
  logic              ID_EX_RegWrite;
  logic              Fwd_signal;
  logic              Busy;
  logic              EX_WB_Valid;
  logic              EX_WB_RegWrite;
  logic [2:0]        EX_WB_Write_Reg_Num;
  logic [DATA_W-1:0] EX_WB_Write_Data;

  ex_wb_stage #(.DATA_W(DATA_W), .SHAMT_W(SHAMT_W)) dut (
    .Clk                 (Clk),
    .Reset_n             (Reset_n),
    .In_Valid            (In_Valid),
    .Flush               (Flush),
    .ID_EX_Alu_Op        (ID_EX_Alu_Op),
    .ID_EX_Read_Data1    (ID_EX_Read_Data1),
    .ID_EX_Read_Data2    (ID_EX_Read_Data2),
    .ID_EX_Write_Reg_Num (ID_EX_Write_Reg_Num),
    .ID_EX_RegWrite      (ID_EX_RegWrite),
    .Fwd_signal          (Fwd_signal),
    .Busy                (Busy),
    .EX_WB_Valid         (EX_WB_Valid),
    .EX_WB_RegWrite      (EX_WB_RegWrite),
    .EX_WB_Write_Reg_Num (EX_WB_Write_Reg_Num),
    .EX_WB_Write_Data    (EX_WB_Write_Data)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  typedef struct {
    logic [2:0]        op;
    logic [DATA_W-1:0] a;
    logic [DATA_W-1:0] b;
    logic [2:0]        num;
    logic              rw;
    logic              fwd;
    logic [DATA_W-1:0] exp;
  } vec_t;

  typedef struct {
    logic              rw;
    logic [2:0]        num;
    logic [DATA_W-1:0] data;
  } exp_t;

  exp_t sb_q[$];
  int tests = 0;
  int fails = 0;
  logic [DATA_W-1:0] last_data;
  logic [2:0]        last_num;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    tests++;
    if (act !== req) begin
      fails++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, req);
    end
  endtask

  task automatic drive(input logic iv, input logic fl, input logic [2:0] op,
                       input logic [DATA_W-1:0] a, input logic [DATA_W-1:0] b,
                       input logic [2:0] num, input logic rw, input logic fwd);
    In_Valid            = iv;
    Flush               = fl;
    ID_EX_Alu_Op        = op;
    ID_EX_Read_Data1    = a;
    ID_EX_Read_Data2    = b;
    ID_EX_Write_Reg_Num = num;
    ID_EX_RegWrite      = rw;
    Fwd_signal          = fwd;
  endtask

  // Pop the next expected write-back and compare it with the EX/WB outputs.
  task automatic check_wb(input string name);
    exp_t e;
    if (sb_q.size() == 0) begin
      check({name, "_sb_empty"}, 32'd1, 32'd0);
      return;
    end
    e = sb_q.pop_front();
    check({name, "_valid"}, 32'(EX_WB_Valid), 32'd1);
    check({name, "_rw"},    32'(EX_WB_RegWrite), 32'(e.rw));
    check({name, "_num"},   32'(EX_WB_Write_Reg_Num), 32'(e.num));
    check({name, "_data"},  32'(EX_WB_Write_Data), 32'(e.data));
    check({name, "_busy"},  32'(Busy), 32'd0);
    last_data = e.data;
    last_num  = e.num;
    $display("[TB] %s: num=%0d data=0x%02h rw=%0b", name, EX_WB_Write_Reg_Num,
             EX_WB_Write_Data, EX_WB_RegWrite);
  endtask

  task automatic single(input string name, input vec_t v);
    @(negedge Clk);
    drive(1'b1, 1'b0, v.op, v.a, v.b, v.num, v.rw, v.fwd);
    sb_q.push_back('{rw: v.rw, num: v.num, data: v.exp});
    @(posedge Clk); #1;
    check_wb(name);
  endtask

  // Issue a multiply; inputs during Busy are either idle or random noise.
  task automatic run_mul(input string name, input logic [DATA_W-1:0] a,
                         input logic [DATA_W-1:0] b, input logic fwd,
                         input logic [DATA_W-1:0] a_eff, input logic [2:0] num,
                         input logic noise);
    int busy_cycles;
    logic [15:0] prod;
    @(negedge Clk);
    drive(1'b1, 1'b0, MUL, a, b, num, 1'b1, fwd);
    prod = 16'(a_eff) * 16'(b);
    sb_q.push_back('{rw: 1'b1, num: num, data: prod[DATA_W-1:0]});
    @(posedge Clk); #1;
    check({name, "_e0_busy"},  32'(Busy), 32'd1);
    check({name, "_e0_valid"}, 32'(EX_WB_Valid), 32'd0);
    busy_cycles = 1;
    for (int i = 0; i < 20; i++) begin
      @(negedge Clk);
      if (noise)
        drive(1'($urandom), 1'b0, 3'($urandom), 8'($urandom), 8'($urandom),
              3'($urandom), 1'($urandom), 1'($urandom));
      else
        drive(1'b0, 1'b0, ADD, 8'h00, 8'h00, 3'd0, 1'b0, 1'b0);
      @(posedge Clk); #1;
      if (!Busy) break;
      busy_cycles++;
      if (EX_WB_RegWrite !== 1'b0 || EX_WB_Valid !== 1'b0)
        check({name, "_wb_during_busy"}, {EX_WB_Valid, EX_WB_RegWrite}, 32'd0);
    end
    check({name, "_busy_cycles"}, 32'(busy_cycles), 32'(DATA_W));
    check_wb(name);
    @(negedge Clk);
    drive(1'b0, 1'b0, ADD, 8'h00, 8'h00, 3'd0, 1'b0, 1'b0);
  endtask

  vec_t vecs[12];

  initial begin
    vecs[0]  = '{ADD,  8'h05, 8'h00, 3'd3, 1'b1, 1'b0, 8'h05};
    vecs[1]  = '{ADD,  8'h00, 8'h02, 3'd3, 1'b1, 1'b1, 8'h07};
    vecs[2]  = '{ADD,  8'h01, 8'h02, 3'd4, 1'b1, 1'b0, 8'h03};
    vecs[3]  = '{SUB,  8'h00, 8'h01, 3'd1, 1'b1, 1'b0, 8'hFF};
    vecs[4]  = '{SHL,  8'h81, 8'h09, 3'd2, 1'b1, 1'b0, 8'h02};
    vecs[5]  = '{SHR,  8'h80, 8'h07, 3'd2, 1'b1, 1'b0, 8'h01};
    vecs[6]  = '{AND_, 8'hF0, 8'h3C, 3'd5, 1'b1, 1'b0, 8'h30};
    vecs[7]  = '{OR_,  8'h00, 8'h0C, 3'd5, 1'b1, 1'b1, 8'h3C};
    vecs[8]  = '{XOR_, 8'h11, 8'hFF, 3'd6, 1'b0, 1'b1, 8'hC3};
    vecs[9]  = '{SUB,  8'h00, 8'h03, 3'd7, 1'b1, 1'b1, 8'hC0};
    vecs[10] = '{ADD,  8'hFF, 8'h02, 3'd0, 1'b1, 1'b0, 8'h01};
    vecs[11] = '{ADD,  8'h05, 8'h02, 3'd3, 1'b1, 1'b0, 8'h07};

    drive(1'b0, 1'b0, ADD, 8'h00, 8'h00, 3'd0, 1'b0, 1'b0);
    Reset_n = 1'b1;
    #2 Reset_n = 1'b0;
    #1;
    check("reset_outputs", {Busy, EX_WB_Valid, EX_WB_RegWrite, EX_WB_Write_Reg_Num,
          EX_WB_Write_Data}, 32'd0);
    repeat (2) @(posedge Clk);
    @(negedge Clk) Reset_n = 1'b1;

    // Table of single-cycle ops, including back-to-back forwarding.
    for (int i = 0; i < 12; i++)
      single($sformatf("vec%0d", i), vecs[i]);

    // Bubble after writing 0x07 to r3: data and number hold.
    @(negedge Clk);
    drive(1'b0, 1'b0, ADD, 8'h11, 8'h22, 3'd6, 1'b1, 1'b0);
    @(posedge Clk); #1;
    check("bubble_valid", {EX_WB_Valid, EX_WB_RegWrite}, 32'd0);
    check("bubble_num",   32'(EX_WB_Write_Reg_Num), 32'd3);
    check("bubble_data",  32'(EX_WB_Write_Data), 32'h07);
    $display("[TB] bubble: valid=%0b data=0x%02h", EX_WB_Valid, EX_WB_Write_Data);

    // Flush coincident with a valid instruction in IDLE.
    @(negedge Clk);
    drive(1'b1, 1'b1, ADD, 8'h01, 8'h01, 3'd6, 1'b1, 1'b0);
    @(posedge Clk); #1;
    check("flush_idle_valid", {EX_WB_Valid, EX_WB_RegWrite}, 32'd0);
    check("flush_idle_data",  32'(EX_WB_Write_Data), 32'h07);
    check("flush_idle_num",   32'(EX_WB_Write_Reg_Num), 32'd3);
    $display("[TB] flush_idle: valid=%0b data=0x%02h", EX_WB_Valid, EX_WB_Write_Data);

    // Flush coincident with a MUL in IDLE must not start it.
    @(negedge Clk);
    drive(1'b1, 1'b1, MUL, 8'h03, 8'h03, 3'd6, 1'b1, 1'b0);
    @(posedge Clk); #1;
    check("flush_mul_accept_busy", 32'(Busy), 32'd0);
    check("flush_mul_accept_valid", {EX_WB_Valid, EX_WB_RegWrite}, 32'd0);
    @(negedge Clk);
    drive(1'b0, 1'b0, ADD, 8'h00, 8'h00, 3'd0, 1'b0, 1'b0);

    // Multiplies: quiet, with input noise, zero wrap, and forwarded operand A.
    run_mul("mul_0d_0b", 8'h0D, 8'h0B, 1'b0, 8'h0D, 3'd5, 1'b0);
    run_mul("mul_noise", 8'h0D, 8'h0B, 1'b0, 8'h0D, 3'd6, 1'b1);
    run_mul("mul_10_10", 8'h10, 8'h10, 1'b0, 8'h10, 3'd2, 1'b1);
    run_mul("mul_fwd",   8'h55, 8'h02, 1'b1, last_data, 3'd1, 1'b0);

    // Flush mid-multiply when the counter reads 3.
    @(negedge Clk);
    drive(1'b1, 1'b0, MUL, 8'h0D, 8'h0B, 3'd5, 1'b1, 1'b0);
    @(posedge Clk); #1;
    check("mflush_e0_busy", 32'(Busy), 32'd1);
    for (int i = 0; i < 3; i++) begin
      @(negedge Clk);
      drive(1'b0, 1'b0, ADD, 8'h00, 8'h00, 3'd0, 1'b0, 1'b0);
      @(posedge Clk); #1;
    end
    @(negedge Clk);
    drive(1'b1, 1'b1, ADD, 8'h09, 8'h09, 3'd4, 1'b1, 1'b0);
    @(posedge Clk); #1;
    check("mflush_busy",  32'(Busy), 32'd0);
    check("mflush_valid", {EX_WB_Valid, EX_WB_RegWrite}, 32'd0);
    check("mflush_data",  32'(EX_WB_Write_Data), 32'(last_data));
    check("mflush_num",   32'(EX_WB_Write_Reg_Num), 32'(last_num));
    $display("[TB] mflush: busy=%0b valid=%0b data=0x%02h", Busy, EX_WB_Valid,
             EX_WB_Write_Data);
    @(negedge Clk) Flush = 1'b0;
    single("after_flush_add", '{ADD, 8'h02, 8'h03, 3'd1, 1'b1, 1'b0, 8'h05});

    // Asynchronous reset in the middle of a multiply.
    @(negedge Clk);
    drive(1'b1, 1'b0, MUL, 8'h07, 8'h07, 3'd2, 1'b1, 1'b0);
    @(posedge Clk); #1;
    @(negedge Clk);
    drive(1'b0, 1'b0, ADD, 8'h00, 8'h00, 3'd0, 1'b0, 1'b0);
    @(posedge Clk); #3;
    check("areset_pre_busy", 32'(Busy), 32'd1);
    Reset_n = 1'b0;
    #1;
    check("areset_outputs", {Busy, EX_WB_Valid, EX_WB_RegWrite, EX_WB_Write_Reg_Num,
          EX_WB_Write_Data}, 32'd0);
    $display("[TB] async_reset: busy=%0b data=0x%02h", Busy, EX_WB_Write_Data);
    sb_q.delete();
    @(negedge Clk) Reset_n = 1'b1;
    single("post_reset_add", '{ADD, 8'h10, 8'h20, 3'd7, 1'b1, 1'b0, 8'h30});

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  // Global watchdog so the bench always terminates.
  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    fails++;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/ex_wb_stage.md
Name: ex_wb_stage

Overview:
- Execute stage plus EX/WB pipeline register of the 3-stage pipelined core.
- Sits downstream of the ID/EX register and the forwarding unit.
- Consumes Fwd_signal to select operand A: either the ID/EX read data, or its own registered EX_WB_Write_Data.
- Performs the ALU op, including an iterative multi-cycle multiply, and registers the result, destination and RegWrite for write-back. Those registered values also feed the forwarding unit's compare.

Parameters:
DATA_W, 8, datapath width in bits (power of 2, ≥4)
SHAMT_W, 3, shift-amount width = log2(DATA_W)

Ports:
Clk  input  1  clock, rising edge
Reset_n  input  1  asynchronous active-low reset
In_Valid  input  1  ID/EX holds a valid instruction
Flush  input  1  synchronous kill of the in-flight instruction
ID_EX_Alu_Op  input  3  operation select
ID_EX_Read_Data1  input  DATA_W  operand A from the register file
ID_EX_Read_Data2  input  DATA_W  operand B (register or immediate); never forwarded
ID_EX_Write_Reg_Num  input  3  destination register
ID_EX_RegWrite  input  1  instruction writes a register
Fwd_signal  input  1  from the forwarding unit: operand A = EX_WB_Write_Data
Busy  output  1  stall request; upstream holds ID/EX while high
EX_WB_Valid  output  1  EX/WB holds a completed instruction
EX_WB_RegWrite  output  1  write enable to the register file and forwarding unit
EX_WB_Write_Reg_Num  output  3  destination register
EX_WB_Write_Data  output  DATA_W  result

Behaviour:
- Reset (Reset_n low, asynchronous): state=IDLE, counter=0, multiplier registers=0, all outputs 0.
- Operand select: A = Fwd_signal ? EX_WB_Write_Data : ID_EX_Read_Data1 (combinational); B = ID_EX_Read_Data2.
- Op codes, all results modulo 2^DATA_W:
  - 000 ADD, 001 SUB, 010 AND, 011 OR, 100 XOR
  - 101 SHL by B[SHAMT_W-1:0]; 110 SHR (logical) by B[SHAMT_W-1:0]
  - 111 MUL, low DATA_W bits of the product
- FSM states: IDLE, MUL. Busy = (state==MUL), combinational from the state register.
- IDLE, In_Valid=1, op≠111, Flush=0:
  - Result registered at the next edge (1-cycle latency).
  - EX_WB_Valid=1; EX_WB_RegWrite=ID_EX_RegWrite; Write_Reg_Num and Write_Data loaded.
- IDLE, In_Valid=1, op=111, Flush=0 (accept edge E0):
  - Capture A, B and destination; clear accumulator; counter=0; go to MUL.
  - EX_WB_Valid=0 and EX_WB_RegWrite=0 from E0 onward.
- MUL: shift-add, one multiplier bit per edge.
  - At edge E0+DATA_W, load the accumulated product low bits into EX_WB with Valid=1 and RegWrite=captured RegWrite, then return to IDLE.
  - Busy is high for exactly DATA_W cycles.
  - ID/EX inputs, including In_Valid and Fwd_signal, are ignored while Busy.
- Bubble (IDLE, In_Valid=0): EX_WB_Valid=0, EX_WB_RegWrite=0; Write_Reg_Num and Write_Data hold their previous values.
- Flush: highest synchronous priority.
  - In IDLE, the coincident instruction is discarded.
  - In MUL, the multiply is aborted and state returns to IDLE.
  - In both cases the next edge gives Valid=0, RegWrite=0, data held, and Busy low after that edge.
  - An instruction presented on the flush edge is not accepted.
- Forwarding uses the register value of EX_WB_Write_Data. The multiply captures operand A at E0, so later changes to EX_WB data do not affect it.
- Back-to-back dependent single-cycle ops forward every cycle with no stall.

Test Plan:
- Reset: assert Reset_n=0 mid-run, asynchronously with no clock edge -> all outputs 0 immediately; state IDLE.
- Forwarding with no stall:
  - ADD 5+0 to r3, then next cycle ADD reading r3 with Fwd_signal=1, stale Read_Data1=0x00, B=0x02 -> second result 0x07.
  - Third op with Fwd_signal=0 and Read_Data1=0x01, B=0x02 -> 0x03.
- Wrap and shifts:
  - SUB 0x00-0x01 -> 0xFF.
  - SHL 0x81 by B=0x09 (uses B[2:0]=1) -> 0x02.
  - SHR 0x80 by 7 -> 0x01.
- Multiply 0x0D*0x0B:
  - Busy high exactly 8 cycles; EX_WB_RegWrite=0 during Busy.
  - Result 0x8F with Valid=1 at E0+8.
  - 0x10*0x10 -> 0x00.
  - In_Valid toggling during Busy has no effect.
- Flush mid-multiply (counter=3) -> Busy low after that edge, no register write; an ADD presented the following cycle completes normally.
- Bubble/flush: In_Valid=0 after a write of 0x07 to r3 -> Valid=0, RegWrite=0, data/num remain 0x07/3; Flush with In_Valid=1 same edge -> no write.
